// File: rtl/control_sequencer_if.sv
// Datapath control bundle for control_sequencer: sequencer inputs (run, memory
// handshake, IR word, single-step) and every datapath control it drives.
interface control_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic             mem_ready;
    logic [31:0]      ir;
    logic             step;

    logic PCin, PCout, IRin, MARin, MDRin, MDRout, read;
    logic HIin, HIout, LOin, LOout, Yin, Zin, ZHighout, ZLowout;
    logic InPortin, InPortout, OutPortin, OutPortout, Cin, Cout;
    logic Rin, Rout;
    logic [3:0]       reg_select;
    logic [3:0]       ALU_operation;

    logic             busy;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    // Sequencer side
    modport master (
        input  run, mem_ready, ir, step,
        output PCin, PCout, IRin, MARin, MDRin, MDRout, read,
        output HIin, HIout, LOin, LOout, Yin, Zin, ZHighout, ZLowout,
        output InPortin, InPortout, OutPortin, OutPortout, Cin, Cout,
        output Rin, Rout, reg_select, ALU_operation,
        output busy, halted, illegal, retired
    );

    // Datapath / environment side
    modport slave (
        output run, mem_ready, ir, step,
        input  PCin, PCout, IRin, MARin, MDRin, MDRout, read,
        input  HIin, HIout, LOin, LOout, Yin, Zin, ZHighout, ZLowout,
        input  InPortin, InPortout, OutPortin, OutPortout, Cin, Cout,
        input  Rin, Rout, reg_select, ALU_operation,
        input  busy, halted, illegal, retired
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the 32-bit bus datapath.
// Optional feature macro: SEQ_SINGLE_STEP_EN (pause after every instruction
// until a step pulse). CNT_W must match the interface instance's CNT_W.
module control_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input logic               clock,
    input logic               clear,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StPause, StHalt
    } state_e;

`ifdef SEQ_SINGLE_STEP_EN
    localparam state_e StDone = StPause;
`else
    localparam state_e StDone = StT0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             t1_wait_q;  // already stalled in T1, so PC was loaded
    logic             last;       // final execute cycle of an instruction

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_rtype, is_muldiv, is_negnot, is_ld, is_halt;

    assign op = bus.ir[31:27];
    assign ra = bus.ir[26:23];
    assign rb = bus.ir[22:19];
    assign rc = bus.ir[18:15];

    assign is_rtype  = (op >= 5'd3) && (op <= 5'd11);
    assign is_muldiv = (op == 5'd14) || (op == 5'd15);
    assign is_negnot = (op == 5'd16) || (op == 5'd17);
    assign is_ld     = (op == 5'd0);
    assign is_halt   = (op == 5'd27);

    logic unused_ir;
    assign unused_ir = ^bus.ir[14:0];
`ifndef SEQ_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = bus.step;
`endif

    // State, retire counter and T1 stall tracking
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= StIdle;
            retired_q <= '0;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= (state_q == StT1) && !bus.mem_ready;
            if (last) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Next state and datapath control decode
    always_comb begin
        state_d           = state_q;
        last              = 1'b0;
        bus.PCin          = 1'b0;
        bus.PCout         = 1'b0;
        bus.IRin          = 1'b0;
        bus.MARin         = 1'b0;
        bus.MDRin         = 1'b0;
        bus.MDRout        = 1'b0;
        bus.read          = 1'b0;
        bus.HIin          = 1'b0;
        bus.HIout         = 1'b0;
        bus.LOin          = 1'b0;
        bus.LOout         = 1'b0;
        bus.Yin           = 1'b0;
        bus.Zin           = 1'b0;
        bus.ZHighout      = 1'b0;
        bus.ZLowout       = 1'b0;
        bus.InPortin      = 1'b0;
        bus.InPortout     = 1'b0;
        bus.OutPortin     = 1'b0;
        bus.OutPortout    = 1'b0;
        bus.Cin           = 1'b0;
        bus.Cout          = 1'b0;
        bus.Rin           = 1'b0;
        bus.Rout          = 1'b0;
        bus.reg_select    = 4'd0;
        bus.ALU_operation = 4'd0;
        bus.illegal       = 1'b0;

        case (state_q)
            StIdle: if (bus.run) state_d = StT0;
            StT0: begin
                bus.PCout         = 1'b1;
                bus.MARin         = 1'b1;
                bus.Zin           = 1'b1;
                bus.ALU_operation = 4'd13;
                state_d           = StT1;
            end
            StT1: begin
                bus.ZLowout = 1'b1;
                bus.PCin    = !t1_wait_q;
                bus.read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) state_d = StT2;
            end
            StT2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = StT3;
            end
            StT3: begin
                state_d = StT4;
                if (is_ld) begin
                    bus.Rout = 1'b1; bus.reg_select = rb; bus.MARin = 1'b1;
                end else if (is_rtype) begin
                    bus.Rout = 1'b1; bus.reg_select = rb; bus.Yin = 1'b1;
                end else if (is_muldiv) begin
                    bus.Rout = 1'b1; bus.reg_select = ra; bus.Yin = 1'b1;
                end else if (is_negnot) begin
                    bus.Rout = 1'b1; bus.reg_select = rb; bus.Zin = 1'b1;
                    bus.ALU_operation = op[0] ? 4'd12 : 4'd11;
                end else begin
                    // Single-cycle ops; undefined opcodes act as nop
                    last = 1'b1;
                    case (op)
                        5'd22: begin bus.InPortout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
                        5'd23: begin bus.Rout = 1'b1; bus.OutPortin = 1'b1; bus.reg_select = ra; end
                        5'd24: begin bus.HIout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
                        5'd25: begin bus.LOout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
                        5'd26, 5'd27: ;
                        default: bus.illegal = 1'b1;
                    endcase
                end
            end
            StT4: begin
                state_d = StT5;
                if (is_rtype) begin
                    bus.Rout = 1'b1; bus.reg_select = rc; bus.Zin = 1'b1;
                    bus.ALU_operation = 4'(op - 5'd3);
                end else if (is_muldiv) begin
                    bus.Rout = 1'b1; bus.reg_select = rb; bus.Zin = 1'b1;
                    bus.ALU_operation = op[0] ? 4'd10 : 4'd9;
                end else if (is_negnot) begin
                    bus.ZLowout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra;
                    last = 1'b1;
                end else begin
                    bus.read  = 1'b1;
                    bus.MDRin = 1'b1;
                    if (!bus.mem_ready) state_d = StT4;
                end
            end
            StT5: begin
                if (is_muldiv) begin
                    bus.ZLowout = 1'b1; bus.LOin = 1'b1;
                    state_d = StT6;
                end else if (is_rtype) begin
                    bus.ZLowout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra;
                    last = 1'b1;
                end else begin
                    bus.MDRout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra;
                    last = 1'b1;
                end
            end
            StT6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
                last         = 1'b1;
            end
            StPause: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (bus.step) state_d = StT0;
`else
                state_d = StT0;
`endif
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase

        if (last) state_d = is_halt ? StHalt : StDone;
    end

    assign bus.busy    = (state_q != StIdle) && (state_q != StHalt);
    assign bus.halted  = (state_q == StHalt);
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: an instruction stream is expanded into
// per-cycle expected control steps from the opcode table and compared each cycle.
module tb_control_sequencer;
    localparam int unsigned CNT_W = 16;

    localparam logic [22:0] M_PCIN = 23'd1 << 0,  M_PCOUT = 23'd1 << 1,  M_IRIN = 23'd1 << 2;
    localparam logic [22:0] M_MARIN = 23'd1 << 3, M_MDRIN = 23'd1 << 4,  M_MDROUT = 23'd1 << 5;
    localparam logic [22:0] M_READ = 23'd1 << 6,  M_HIIN = 23'd1 << 7,   M_HIOUT = 23'd1 << 8;
    localparam logic [22:0] M_LOIN = 23'd1 << 9,  M_LOOUT = 23'd1 << 10, M_YIN = 23'd1 << 11;
    localparam logic [22:0] M_ZIN = 23'd1 << 12,  M_ZHI = 23'd1 << 13,   M_ZLO = 23'd1 << 14;
    localparam logic [22:0] M_INPOUT = 23'd1 << 16, M_OUTPIN = 23'd1 << 17;
    localparam logic [22:0] M_RIN = 23'd1 << 21,  M_ROUT = 23'd1 << 22;

    localparam int W_NONE = 0, W_MEM = 1, W_STEP = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    typedef struct {
        logic [22:0] ctl;
        int          sel;
        int          alu;
        int          wt;
        bit          last;
        bit          ill;
        bit          hlt;
        logic [31:0] word;
    } step_t;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    control_sequencer_if #(.CNT_W(CNT_W)) bus ();
    control_sequencer #(.CNT_W(CNT_W)) dut (.clock(clock), .clear(clear), .bus(bus));

    logic [22:0] ctl_act;
    assign ctl_act = {bus.Rout, bus.Rin, bus.Cout, bus.Cin, bus.OutPortout, bus.OutPortin,
                      bus.InPortout, bus.InPortin, bus.ZLowout, bus.ZHighout, bus.Zin, bus.Yin,
                      bus.LOout, bus.LOin, bus.HIout, bus.HIin, bus.read, bus.MDRout, bus.MDRin,
                      bus.MARin, bus.IRin, bus.PCout, bus.PCin};

    step_t            q[$];
    logic [31:0]      prog[$];
    bit               mr_script[$];
    int               mode;
    logic [CNT_W-1:0] m_retired;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic [22:0] c, input int sel, input int alu, input int wt,
                        input bit last, input bit ill, input bit hlt, input logic [31:0] word);
        step_t s;
        s.ctl = c; s.sel = sel; s.alu = alu; s.wt = wt;
        s.last = last; s.ill = ill; s.hlt = hlt; s.word = word;
        q.push_back(s);
`ifdef SEQ_SINGLE_STEP_EN
        if (last && !hlt) begin
            s.ctl = '0; s.sel = 0; s.alu = 0; s.wt = W_STEP;
            s.last = 0; s.ill = 0; s.hlt = 0;
            q.push_back(s);
        end
`endif
    endtask

    task automatic load_next();
        logic [31:0] w;
        int op, ra, rb, rc;
        w  = (prog.size() > 0) ? prog.pop_front() : 32'hD000_0000;
        op = int'(w[31:27]); ra = int'(w[26:23]); rb = int'(w[22:19]); rc = int'(w[18:15]);
        push(M_PCOUT | M_MARIN | M_ZIN, 0, 13, W_NONE, 0, 0, 0, 0);
        push(M_ZLO | M_PCIN | M_READ | M_MDRIN, 0, 0, W_MEM, 0, 0, 0, 0);
        push(M_MDROUT | M_IRIN, 0, 0, W_NONE, 0, 0, 0, w);
        if (op >= 3 && op <= 11) begin
            push(M_ROUT | M_YIN, rb, 0, W_NONE, 0, 0, 0, 0);
            push(M_ROUT | M_ZIN, rc, op - 3, W_NONE, 0, 0, 0, 0);
            push(M_ZLO | M_RIN, ra, 0, W_NONE, 1, 0, 0, 0);
        end else if (op == 14 || op == 15) begin
            push(M_ROUT | M_YIN, ra, 0, W_NONE, 0, 0, 0, 0);
            push(M_ROUT | M_ZIN, rb, (op == 14) ? 9 : 10, W_NONE, 0, 0, 0, 0);
            push(M_ZLO | M_LOIN, 0, 0, W_NONE, 0, 0, 0, 0);
            push(M_ZHI | M_HIIN, 0, 0, W_NONE, 1, 0, 0, 0);
        end else if (op == 16 || op == 17) begin
            push(M_ROUT | M_ZIN, rb, (op == 16) ? 11 : 12, W_NONE, 0, 0, 0, 0);
            push(M_ZLO | M_RIN, ra, 0, W_NONE, 1, 0, 0, 0);
        end else if (op == 0) begin
            push(M_ROUT | M_MARIN, rb, 0, W_NONE, 0, 0, 0, 0);
            push(M_READ | M_MDRIN, 0, 0, W_MEM, 0, 0, 0, 0);
            push(M_MDROUT | M_RIN, ra, 0, W_NONE, 1, 0, 0, 0);
        end else if (op == 22) push(M_INPOUT | M_RIN, ra, 0, W_NONE, 1, 0, 0, 0);
        else if (op == 23) push(M_ROUT | M_OUTPIN, ra, 0, W_NONE, 1, 0, 0, 0);
        else if (op == 24) push(M_HIOUT | M_RIN, ra, 0, W_NONE, 1, 0, 0, 0);
        else if (op == 25) push(M_LOOUT | M_RIN, ra, 0, W_NONE, 1, 0, 0, 0);
        else if (op == 26) push('0, 0, 0, W_NONE, 1, 0, 0, 0);
        else if (op == 27) push('0, 0, 0, W_NONE, 1, 0, 1, 0);
        else push('0, 0, 0, W_NONE, 1, 1, 0, 0);
    endtask

    task automatic compare_cycle();
        logic [22:0] e_ctl = '0;
        int e_sel = 0, e_alu = 0;
        bit e_ill = 0, e_busy = 0, e_halted = 0;
        if (mode == M_RUN && q.size() > 0) begin
            e_ctl = q[0].ctl; e_sel = q[0].sel; e_alu = q[0].alu; e_ill = q[0].ill;
            e_busy = 1;
        end else if (mode == M_HALT) begin
            e_halted = 1;
        end
        check_eq("controls", 32'(ctl_act), 32'(e_ctl));
        check_eq("reg_select", 32'(bus.reg_select), e_sel);
        check_eq("ALU_operation", 32'(bus.ALU_operation), e_alu);
        check_eq("illegal", 32'(bus.illegal), 32'(e_ill));
        check_eq("busy", 32'(bus.busy), 32'(e_busy));
        check_eq("halted", 32'(bus.halted), 32'(e_halted));
        check_eq("retired", 32'(bus.retired), 32'(m_retired));
    endtask

    // One clock: compare at negedge, drive inputs, advance the model, load IR after the edge
    task automatic cycle(input bit drive_run, input int force_mr);
        step_t h;
        bit stay;
        bit ld_ir = 0;
        logic [31:0] w = '0;
        @(negedge clock);
        if (mode == M_RUN && q.size() == 0) load_next();
        compare_cycle();
        bus.run  = (mode == M_IDLE) ? drive_run : ($urandom_range(0, 1) == 1);
        bus.step = ($urandom_range(0, 3) == 0);
        if (mode == M_RUN && q[0].wt == W_MEM && mr_script.size() > 0)
            bus.mem_ready = mr_script.pop_front();
        else if (force_mr >= 0) bus.mem_ready = (force_mr != 0);
        else bus.mem_ready = ($urandom_range(0, 9) < 7);
        if (mode == M_IDLE) begin
            if (bus.run) mode = M_RUN;
        end else if (mode == M_RUN) begin
            h = q[0];
            stay = (h.wt == W_MEM && !bus.mem_ready) || (h.wt == W_STEP && !bus.step);
            if (stay) q[0].ctl = q[0].ctl & ~M_PCIN;
            else begin
                void'(q.pop_front());
                if (h.last) m_retired = m_retired + 1'b1;
                if (h.hlt) mode = M_HALT;
                if ((h.ctl & M_IRIN) != 0) begin ld_ir = 1; w = h.word; end
            end
        end
        @(posedge clock);
        #1;
        if (ld_ir) bus.ir = w;
        cyc++;
    endtask

    task automatic apply_clear();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        mode = M_IDLE;
        q.delete();
        m_retired = '0;
    endtask

    initial begin
        logic [31:0] w;
        int op, n;
        clear = 1'b1; bus.run = 1'b0; bus.mem_ready = 1'b1; bus.step = 1'b0; bus.ir = '0;
        mode = M_IDLE; m_retired = '0;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        repeat (2) cycle(0, -1);

        // Directed add with a 3-cycle T1 stall, then mul, random stream, op 31, halt
        prog.push_back(32'h1A98_0000);
        prog.push_back((32'd14 << 27) | (32'd2 << 23) | (32'd4 << 19));
        for (int i = 0; i < 40; i++) begin
            do op = $urandom_range(0, 31); while (op == 27);
            w = $urandom();
            w[31:27] = 5'(op);
            prog.push_back(w);
        end
        prog.push_back(32'd31 << 27);
        prog.push_back(32'd27 << 27);
        mr_script = '{0, 0, 0};
        cycle(1, -1);
        n = 0;
        while (mode != M_HALT && n < 5000) begin cycle(0, -1); n++; end
        @(negedge clock);
        check_eq("halt_reached", 32'(bus.halted), 32'd1);
        repeat (5) cycle(0, -1);

        // clear out of HALT
        apply_clear();
        repeat (2) cycle(0, -1);

        // clear in the middle of ld's memory wait
        prog.delete();
        prog.push_back(32'hD000_0000);
        prog.push_back((32'd7 << 23) | (32'd9 << 19));
        cycle(1, 1);
        n = 0;
        while (!(mode == M_RUN && q.size() > 0 && q[0].wt == W_MEM && (q[0].ctl & M_PCIN) == 0 &&
                 (q[0].ctl & M_ZLO) == 0) && n < 200) begin
            cycle(0, 1);
            n++;
        end
        check_eq("ld_wait_reached", 32'(n < 200), 32'd1);
        repeat (3) cycle(0, 0);
        apply_clear();
        repeat (3) cycle(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
